// File: rtl/alu_exec_unit.sv
// alu_exec_unit -- sequential execution front-end for the 20-bit ALU datapath.
//
// Accepts {op, a, b, c_in} over in_valid/in_ready. The result is held on
// {res, res_hi, c_out, illegal} under out_valid until out_ready.
// Single-cycle ops register their result on the accept edge. MUL is a
// 20-cycle shift-add that runs LSB-first over the multiplier.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   request handshake; op/a/b/c_in are sampled on accept
//   out_valid/out_ready result handshake
//   res, res_hi         primary / secondary result (MUL high word, SWAP's a)
//   c_out, illegal      carry out, unsupported-opcode flag
//
// Build option: define ALU_MUL_EN to build the multi-cycle multiplier.
// Without it, opcode 10 is reported as illegal.
module alu_exec_unit #(
  parameter int WIDTH = 20,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic [WIDTH-1:0] res_hi,
  output logic             c_out,
  output logic             illegal
);

  localparam logic [3:0] OP_PASS_A = 4'd0, OP_PASS_B = 4'd1, OP_NOT = 4'd2,
                         OP_AND = 4'd3, OP_OR = 4'd4, OP_SHL = 4'd5,
                         OP_SHR = 4'd6, OP_ADD = 4'd7, OP_INC = 4'd8,
                         OP_SWAP = 4'd9, OP_MUL = 4'd10;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d, res_hi_q, res_hi_d;
  logic             c_out_q, c_out_d, illegal_q, illegal_d;

  // Single-cycle result, computed straight from the request inputs.
  logic [WIDTH-1:0] r_res, r_hi;
  logic             r_c, r_ill;

  always_comb begin
    r_res = '0;
    r_hi  = '0;
    r_c   = 1'b0;
    r_ill = 1'b0;
    case (op)
      OP_PASS_A: r_res = a;
      OP_PASS_B: r_res = b;
      OP_NOT:    r_res = ~a;
      OP_AND:    r_res = a & b;
      OP_OR:     r_res = a | b;
      OP_SHL:    r_res = a << b[3:0];
      OP_SHR:    r_res = a >> b[3:0];
      OP_ADD:    {r_c, r_res} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c_in};
      OP_INC:    {r_c, r_res} = {1'b0, a} + (WIDTH+1)'(1);
      OP_SWAP: begin
        r_res = b;
        r_hi  = a;
      end
`ifdef ALU_MUL_EN
      OP_MUL:    ;  // handled by the BUSY sequence
`endif
      default:   r_ill = 1'b1;
    endcase
  end

`ifdef ALU_MUL_EN
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d, mplr_q, mplr_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, partial;

  // Partial product for multiplier bit cnt_q, aligned to its weight.
  assign partial = mplr_q[cnt_q] ? ({{WIDTH{1'b0}}, mcand_q} << cnt_q) : '0;
`endif

  assign in_ready  = rst_n && (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign res       = res_q;
  assign res_hi    = res_hi_q;
  assign c_out     = c_out_q;
  assign illegal   = illegal_q;

  always_comb begin
    state_d   = state_q;
    res_d     = res_q;
    res_hi_d  = res_hi_q;
    c_out_d   = c_out_q;
    illegal_d = illegal_q;
`ifdef ALU_MUL_EN
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    mplr_d    = mplr_q;
    acc_d     = acc_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
`ifdef ALU_MUL_EN
          if (op == OP_MUL) begin
            state_d = S_BUSY;
            mcand_d = a;
            mplr_d  = b;
            cnt_d   = '0;
            acc_d   = '0;
          end else
`endif
          begin
            state_d   = S_DONE;
            res_d     = r_res;
            res_hi_d  = r_hi;
            c_out_d   = r_c;
            illegal_d = r_ill;
          end
        end
      end
`ifdef ALU_MUL_EN
      S_BUSY: begin
        acc_d = acc_q + partial;
        if (cnt_q == CNT_W'(WIDTH-1)) begin
          {res_hi_d, res_d} = acc_q + partial;
          c_out_d   = 1'b0;
          illegal_d = 1'b0;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      res_q     <= '0;
      res_hi_q  <= '0;
      c_out_q   <= 1'b0;
      illegal_q <= 1'b0;
`ifdef ALU_MUL_EN
      cnt_q     <= '0;
      mcand_q   <= '0;
      mplr_q    <= '0;
      acc_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      res_q     <= res_d;
      res_hi_q  <= res_hi_d;
      c_out_q   <= c_out_d;
      illegal_q <= illegal_d;
`ifdef ALU_MUL_EN
      cnt_q     <= cnt_d;
      mcand_q   <= mcand_d;
      mplr_q    <= mplr_d;
      acc_q     <= acc_d;
`endif
    end
  end

endmodule
